// File: rtl/i2c_key_slave_p.sv
// i2c_key_slave_p: I2C slave that receives a KEY_BYTES-byte key on writes and
// returns a loadable RD_BYTES-byte buffer on reads.
// Ports:
//   clk, rst        - clock and synchronous active-high reset
//   scl, sda_in     - raw asynchronous bus lines
//   sda_out         - 0 pulls SDA low, 1 releases it
//   wr_en, wr_data  - load request and data for the read buffer (byte 0 = MSB byte)
//   rd_full         - read buffer holds unsent data
//   key             - last valid key, first received byte in the MSBs
//   key_valid/err   - one-cycle result pulses after a write transaction
//   busy            - bus transaction in progress (START seen, no STOP yet)
module i2c_key_slave_p #(
  parameter logic [6:0]  SLAVE_ADDR = 7'h1E,
  parameter int unsigned KEY_BYTES  = 16,
  parameter int unsigned RD_BYTES   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    scl,
  input  logic                    sda_in,
  output logic                    sda_out,
  input  logic                    wr_en,
  input  logic [RD_BYTES*8-1:0]   wr_data,
  output logic                    rd_full,
  output logic [KEY_BYTES*8-1:0]  key,
  output logic                    key_valid,
  output logic                    key_err,
  output logic                    busy
);

  localparam int unsigned KW   = KEY_BYTES * 8;
  localparam int unsigned RW   = RD_BYTES * 8;
  localparam int unsigned CNTW = $clog2(KEY_BYTES + 1);
  localparam int unsigned IDXW = $clog2(RD_BYTES + 1);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_ADDR       = 3'd1;
  localparam logic [2:0] S_ADDR_ACK   = 3'd2;
  localparam logic [2:0] S_RX_BYTE    = 3'd3;
  localparam logic [2:0] S_RX_ACK     = 3'd4;
  localparam logic [2:0] S_TX_BYTE    = 3'd5;
  localparam logic [2:0] S_TX_ACK_CHK = 3'd6;
  localparam logic [2:0] S_IGNORE     = 3'd7;

  logic            r_scl_s1, r_scl_s2, r_scl_d;
  logic            r_sda_s1, r_sda_s2, r_sda_d;
  logic [2:0]      r_state, w_state_nxt;
  logic [7:0]      r_shift, r_tx;
  logic [3:0]      r_bit_cnt;
  logic            r_rw, r_ack, r_ack_ph, r_ovf, r_wr_active;
  logic [CNTW-1:0] r_byte_cnt;
  logic [IDXW-1:0] r_tx_idx, w_load_idx;
  logic [KW-1:0]   r_stage, r_key;
  logic [RW-1:0]   r_rd_buf;
  logic            r_rd_full, r_key_valid, r_key_err, r_busy, r_sda_out;
  logic            w_scl_rise, w_scl_fall, w_start, w_stop;
  logic            w_addr_ok, w_wr_good, w_wr_bad;
  logic [7:0]      w_rx_byte, w_buf_byte;

  // Two-flop synchronisers plus a delayed copy for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      r_scl_s1 <= 1'b1; r_scl_s2 <= 1'b1; r_scl_d <= 1'b1;
      r_sda_s1 <= 1'b1; r_sda_s2 <= 1'b1; r_sda_d <= 1'b1;
    end else begin
      r_scl_s1 <= scl;    r_scl_s2 <= r_scl_s1; r_scl_d <= r_scl_s2;
      r_sda_s1 <= sda_in; r_sda_s2 <= r_sda_s1; r_sda_d <= r_sda_s2;
    end
  end

  assign w_scl_rise = r_scl_s2 & ~r_scl_d;
  assign w_scl_fall = ~r_scl_s2 & r_scl_d;
  assign w_start    = r_scl_s2 & r_scl_d & r_sda_d & ~r_sda_s2;
  assign w_stop     = r_scl_s2 & r_scl_d & ~r_sda_d & r_sda_s2;
  assign w_rx_byte  = {r_shift[6:0], r_sda_s2};
  // Reads are only acknowledged when there is buffered data to return
  assign w_addr_ok  = (w_rx_byte[7:1] == SLAVE_ADDR) && (!w_rx_byte[0] || r_rd_full);
  assign w_wr_good  = r_wr_active && !r_ovf && (r_byte_cnt == CNTW'(KEY_BYTES));
  assign w_wr_bad   = r_wr_active && (r_ovf ||
                      ((r_byte_cnt != '0) && (r_byte_cnt != CNTW'(KEY_BYTES))));
  // Address ACK always starts at byte 0; later loads continue from r_tx_idx
  assign w_load_idx = (r_state == S_TX_ACK_CHK) ? r_tx_idx : '0;

  // Read-buffer byte mux; indices past the buffer read as 8'hFF
  always_comb begin
    w_buf_byte = 8'hFF;
    for (int i = 0; i < int'(RD_BYTES); i++) begin
      if (w_load_idx == IDXW'(i)) w_buf_byte = r_rd_buf[RW-8*(i+1) +: 8];
    end
  end

  // Next-state logic; START/STOP override any state
  always_comb begin
    w_state_nxt = r_state;
    if (w_stop) begin
      w_state_nxt = S_IDLE;
    end else if (w_start) begin
      w_state_nxt = S_ADDR;
    end else begin
      case (r_state)
        S_ADDR:       if (w_scl_rise && r_bit_cnt == 4'd7)
                        w_state_nxt = w_addr_ok ? S_ADDR_ACK : S_IGNORE;
        S_ADDR_ACK:   if (w_scl_fall && r_ack_ph)
                        w_state_nxt = r_rw ? S_TX_BYTE : S_RX_BYTE;
        S_RX_BYTE:    if (w_scl_rise && r_bit_cnt == 4'd7) w_state_nxt = S_RX_ACK;
        S_RX_ACK:     if (w_scl_fall && r_ack_ph) w_state_nxt = S_RX_BYTE;
        S_TX_BYTE:    if (w_scl_fall && r_bit_cnt == 4'd8) w_state_nxt = S_TX_ACK_CHK;
        S_TX_ACK_CHK: if (w_scl_rise) w_state_nxt = r_sda_s2 ? S_IGNORE : S_TX_BYTE;
        default:      w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Datapath: shifters, counters, key staging, read buffer and outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift <= '0; r_tx <= 8'hFF; r_bit_cnt <= '0; r_rw <= 1'b0;
      r_ack <= 1'b0; r_ack_ph <= 1'b0; r_ovf <= 1'b0; r_wr_active <= 1'b0;
      r_byte_cnt <= '0; r_tx_idx <= '0; r_stage <= '0; r_key <= '0;
      r_rd_buf <= '0; r_rd_full <= 1'b0; r_key_valid <= 1'b0;
      r_key_err <= 1'b0; r_busy <= 1'b0; r_sda_out <= 1'b1;
    end else begin
      r_key_valid <= 1'b0;
      r_key_err   <= 1'b0;
      if (wr_en && !r_rd_full) begin
        r_rd_buf  <= wr_data;
        r_rd_full <= 1'b1;
      end
      if (w_stop) begin
        r_busy      <= 1'b0;
        r_sda_out   <= 1'b1;
        r_wr_active <= 1'b0;
        if (w_wr_good) begin
          r_key       <= r_stage;
          r_key_valid <= 1'b1;
        end
        r_key_err <= w_wr_bad;
      end else if (w_start) begin
        r_busy      <= 1'b1;
        r_sda_out   <= 1'b1;
        r_bit_cnt   <= '0;
        r_byte_cnt  <= '0;
        r_ovf       <= 1'b0;
        r_ack_ph    <= 1'b0;
        r_wr_active <= 1'b0;
        r_key_err   <= w_wr_bad;
      end else begin
        case (r_state)
          S_ADDR: if (w_scl_rise) begin
            r_shift   <= w_rx_byte;
            r_bit_cnt <= r_bit_cnt + 4'd1;
            if (r_bit_cnt == 4'd7) begin
              r_bit_cnt <= '0;
              r_ack_ph  <= 1'b0;
              r_ack     <= 1'b1;
              if (w_addr_ok) begin
                r_rw <= w_rx_byte[0];
                if (w_rx_byte[0]) begin
                  r_tx     <= w_buf_byte;
                  r_tx_idx <= IDXW'(1);
                  if (RD_BYTES == 1) r_rd_full <= 1'b0;
                end else begin
                  r_wr_active <= 1'b1;
                end
              end
            end
          end
          // First SCL fall drives the (N)ACK, second fall ends the ACK bit
          S_ADDR_ACK, S_RX_ACK: if (w_scl_fall) begin
            if (!r_ack_ph) begin
              r_sda_out <= ~r_ack;
              r_ack_ph  <= 1'b1;
            end else begin
              r_ack_ph  <= 1'b0;
              r_bit_cnt <= '0;
              r_sda_out <= 1'b1;
              if (r_state == S_ADDR_ACK && r_rw) begin
                r_sda_out <= r_tx[7];
                r_tx      <= {r_tx[6:0], 1'b1};
                r_bit_cnt <= 4'd1;
              end
            end
          end
          S_RX_BYTE: if (w_scl_rise) begin
            r_shift   <= w_rx_byte;
            r_bit_cnt <= r_bit_cnt + 4'd1;
            if (r_bit_cnt == 4'd7) begin
              r_bit_cnt <= '0;
              if (r_byte_cnt < CNTW'(KEY_BYTES)) begin
                // Shift staging so the first byte ends up in the MSBs
                r_stage    <= (r_stage << 8) | KW'(w_rx_byte);
                r_byte_cnt <= r_byte_cnt + CNTW'(1);
                r_ack      <= 1'b1;
              end else begin
                r_ovf <= 1'b1;
                r_ack <= 1'b0;
              end
            end
          end
          S_TX_BYTE: if (w_scl_fall) begin
            if (r_bit_cnt < 4'd8) begin
              r_sda_out <= r_tx[7];
              r_tx      <= {r_tx[6:0], 1'b1};
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end else begin
              r_sda_out <= 1'b1;
              r_bit_cnt <= '0;
            end
          end
          S_TX_ACK_CHK: if (w_scl_rise && !r_sda_s2) begin
            r_tx      <= w_buf_byte;
            r_bit_cnt <= '0;
            if (w_load_idx < IDXW'(RD_BYTES)) r_tx_idx <= w_load_idx + IDXW'(1);
            if (w_load_idx == IDXW'(RD_BYTES - 1)) r_rd_full <= 1'b0;
          end
          S_IGNORE: r_sda_out <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign sda_out   = r_sda_out;
  assign rd_full   = r_rd_full;
  assign key       = r_key;
  assign key_valid = r_key_valid;
  assign key_err   = r_key_err;
  assign busy      = r_busy;

endmodule
